// File: rtl/alu_share_arbiter.sv
// Round-robin share of one single-cycle ALU between two valid/ready requesters,
// with a registered, back-pressured response channel tagged by requester id.
module alu_share_arbiter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic            rsp_err,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic            rr_ptr;
  logic            id_p0;
  logic [3:0]      op_p0;
  logic [XLEN-1:0] a_p0;
  logic [XLEN-1:0] b_p0;
  logic            accept_en;
  logic            accept;
  logic            grant;

  function automatic logic op_unsupported(input logic [3:0] op);
    return !(op == 4'b0000 || op == 4'b0001 || op == 4'b0010 || op == 4'b0110);
  endfunction

  // rst_n is active-high; readies are forced low while it is asserted.
  always_comb begin
    accept_en  = !rst_n && ((state == IDLE) || (state == RESP && rsp_ready));
    grant      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    req0_ready = accept_en && req0_valid && !grant;
    req1_ready = accept_en && req1_valid && grant;
    accept     = req0_ready || req1_ready;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      id_p0      <= 1'b0;
      op_p0      <= '0;
      a_p0       <= '0;
      b_p0       <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      // Stage p0: latch the granted request and hand priority to the other port.
      op_p0  <= grant ? req1_op : req0_op;
      a_p0   <= grant ? req1_a  : req0_a;
      b_p0   <= grant ? req1_b  : req0_b;
      id_p0  <= grant;
      rr_ptr <= ~grant;
      state  <= EXEC;
    end else begin
      case (state)
        EXEC: begin
          // Stage p1: ALU has settled on the latched operands; capture response.
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_err    <= op_unsupported(op_p0);
          rsp_id     <= id_p0;
          state      <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: ;
      endcase
    end
  end

  assign alu_ctrl  = op_p0;
  assign alu_a     = a_p0;
  assign alu_b     = b_p0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised and directed bench for alu_share_arbiter against a transaction-level
// scoreboard model plus a behavioural model of the attached ALU.
module tb_alu_share_arbiter;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [3:0]      req0_op = '0, req1_op = '0;
  logic [XLEN-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic            alu_zero;
  logic            rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, rsp_err, busy;
  logic [XLEN-1:0] rsp_result;

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected arithmetic for a request, straight from the op-code table.
  function automatic logic [XLEN-1:0] exp_result(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic logic exp_zero(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return (b - a) == '0;
  endfunction

  function automatic logic exp_err(input logic [3:0] op);
    return !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110});
  endfunction

  // The external single-cycle ALU.
  always_comb begin
    alu_result = exp_result(alu_ctrl, alu_a, alu_b);
    alu_zero   = exp_zero(alu_a, alu_b);
  end

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } req_t;

  typedef struct {
    logic            id;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    int              acc_cyc;
    bit              seen;
  } txn_t;

  req_t pq0[$], pq1[$];
  txn_t sb[$];
  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, last_acc = -1;
  bit   acc0 = 0, acc1 = 0, rdy_rand = 0, force_rdy = 1, tput = 0, prev_stall = 0;
  logic m_rr = 1'b0;
  logic [XLEN-1:0] prev_result;
  logic [2:0]      prev_flags;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    if (acc0) begin void'(pq0.pop_front()); req0_valid = 1'b0; acc0 = 0; end
    if (acc1) begin void'(pq1.pop_front()); req1_valid = 1'b0; acc1 = 0; end
    if (!req0_valid && pq0.size() > 0) begin
      req0_valid = 1'b1; req0_op = pq0[0].op; req0_a = pq0[0].a; req0_b = pq0[0].b;
    end
    if (!req1_valid && pq1.size() > 0) begin
      req1_valid = 1'b1; req1_op = pq1[0].op; req1_a = pq1[0].a; req1_b = pq1[0].b;
    end
    rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : force_rdy;
  endtask

  task automatic monitor();
    bit   exp_can;
    logic g, exp_g;
    txn_t t;
    cyc++;
    exp_can = (sb.size() == 0) || (sb.size() == 1 && rsp_valid && rsp_ready);
    check("busy", busy, sb.size() > 0);
    if (req0_valid || req1_valid) check("ready_any", req0_ready | req1_ready, exp_can);
    if (rsp_valid) begin
      if (sb.size() == 0) check("spurious_rsp", 1, 0);
      else begin
        if (!sb[0].seen) begin
          check("latency", cyc - sb[0].acc_cyc, 2);
          sb[0].seen = 1;
        end
        check("rsp_id", rsp_id, sb[0].id);
        check("rsp_result", rsp_result, exp_result(sb[0].op, sb[0].a, sb[0].b));
        check("rsp_zero", rsp_zero, exp_zero(sb[0].a, sb[0].b));
        check("rsp_err", rsp_err, exp_err(sb[0].op));
        if (prev_stall) begin
          check("stable_result", rsp_result, prev_result);
          check("stable_flags", {rsp_id, rsp_zero, rsp_err}, prev_flags);
        end
        if (rsp_ready) void'(sb.pop_front());
      end
    end else if (sb.size() > 0) begin
      if (sb[0].seen) check("rsp_dropped", 0, 1);
      else if (cyc - sb[0].acc_cyc > 2) check("rsp_late", cyc - sb[0].acc_cyc, 2);
    end
    prev_stall  = rsp_valid && !rsp_ready;
    prev_result = rsp_result;
    prev_flags  = {rsp_id, rsp_zero, rsp_err};
    if (req0_ready || req1_ready) begin
      check("ready_excl", req0_ready & req1_ready, 0);
      g     = req0_ready ? 1'b0 : 1'b1;
      exp_g = (req0_valid && req1_valid) ? m_rr : req1_valid;
      check("grant", g, exp_g);
      if (tput && last_acc >= 0) check("spacing", cyc - last_acc, 2);
      last_acc  = cyc;
      t.id      = g;
      t.op      = g ? req1_op : req0_op;
      t.a       = g ? req1_a : req0_a;
      t.b       = g ? req1_b : req0_b;
      t.acc_cyc = cyc;
      t.seen    = 0;
      sb.push_back(t);
      m_rr = ~g;
      if (g) acc1 = 1; else acc0 = 1;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic run_until_done(input int max);
    int n = 0;
    while ((pq0.size() > 0 || pq1.size() > 0 || sb.size() > 0 || req0_valid || req1_valid)
           && n < max) begin
      step();
      n++;
    end
    check("timeout", n < max, 1);
  endtask

  task automatic push(input bit port, input logic [3:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    if (port) pq1.push_back(r); else pq0.push_back(r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_result"}, rsp_result, 0);
    check({tag, "_rsp_zero"}, rsp_zero, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_alu_ctrl"}, alu_ctrl, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
  endtask

  initial begin
    logic [3:0]      ops[4];
    logic [3:0]      op;
    logic [XLEN-1:0] a, b;
    int              n;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110};

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b0;

    push(0, 4'b0010, 64'd5, 64'd7);
    run_until_done(50);
    push(1, 4'b0110, 64'h10, 64'h10);
    run_until_done(50);

    // Both ports continuously valid with the consumer always ready.
    tput = 1; last_acc = -1;
    push(0, 4'b0000, 64'hF0, 64'h3C); push(0, 4'b0000, 64'hF0, 64'h3C);
    push(1, 4'b0001, 64'hF0, 64'h0F); push(1, 4'b0001, 64'hF0, 64'h0F);
    run_until_done(50);
    tput = 0;

    // Consumer stalls for 5 cycles while port 0 has a second request waiting.
    force_rdy = 0;
    push(0, 4'b0010, 64'h100, 64'h23); push(0, 4'b0110, 64'h9, 64'h4);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    check("stall_reach_resp", rsp_valid, 1);
    repeat (5) step();
    force_rdy = 1;
    run_until_done(50);

    push(0, 4'b1111, 64'd3, 64'd4);
    run_until_done(50);

    rdy_rand = 1;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 4) == 4) ? 4'($urandom) : ops[$urandom_range(0, 3)];
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      push(1'($urandom_range(0, 1)), op, a, b);
    end
    run_until_done(3000);
    rdy_rand = 0; force_rdy = 1;

    // Asynchronous reset while a transaction sits in the execute stage.
    push(0, 4'b0010, 64'hABC, 64'h111);
    n = 0;
    while (sb.size() == 0 && n < 20) begin step(); n++; end
    check("pre_reset_accept", sb.size(), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 1'b0; acc0 = 0; void'(pq0.pop_front());
    #1 check_all_zero("async_reset");
    check("async_reset_ready", req0_ready | req1_ready, 0);
    sb.delete(); m_rr = 1'b0; prev_stall = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (4) step();
    push(0, 4'b0001, 64'h1, 64'h2); push(1, 4'b0000, 64'h3, 64'h3);
    run_until_done(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
